sprite_line_renderer: RTL
=========================

# sprite_line_renderer

Parametrised sprite row renderer for the tile/sprite display engine. It sits between the per-scanline sprite scheduler and the line buffer. On a start command it fetches one row of one sprite frame from the sprite ROM and writes opaque pixels to the line buffer, with horizontal/vertical flip, a configurable ROM latency, and an abort path for end-of-line overrun.

## Interface
- SPR_W, default 16: sprite width in pixels; power of two, at least 2.
- SPR_H, default 16: sprite height in rows; power of two, at least 2.
- FRAME_W, default 8: frame_id width.
- PIX_W, default 16: pixel width; bit PIX_W-1 is the transparency flag (1 = transparent).
- COL_W, default 10: line-buffer column width.
- LINE_W, default 640: visible columns; used only with clipping.
- ROM_LAT, default 1: ROM read latency in cycles, range 1..4.
- AW (localparam): FRAME_W+log2(SPR_H)+log2(SPR_W).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; accepted only when busy=0.
- col_base  in  COL_W  screen column of sprite left edge.
- frame_id  in  FRAME_W  sprite frame.
- row_off  in  log2(SPR_H)  row within sprite.
- hflip, vflip  in  1  mirror controls.
- abort  in  1  stop current row.
- rom_addr  out  AW  registered ROM address.
- rom_q  in  PIX_W  ROM data, valid ROM_LAT cycles after address.
- pixel_col  out  COL_W  line-buffer write column.
- pixel_data  out  PIX_W  line-buffer write data.
- wren  out  1  line-buffer write enable.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, FETCH (addresses issued), DRAIN (awaiting last ROM_LAT returns).
- IDLE + start: latch col_base, frame_id, row, hflip. row = vflip ? SPR_H-1-row_off : row_off. Go to FETCH, clear index i.
- FETCH: rom_addr = {frame_id, row, i}, with i = 0..SPR_W-1, one per cycle. Tag (valid, i) enters a ROM_LAT-deep delay line. After i=SPR_W-1, go to DRAIN.
- Output stage, per returning tag: pixel_col = col_base + (hflip ? SPR_W-1-i : i). Compute the sum in COL_W+1 bits. pixel_data = rom_q.
- wren = tag valid AND rom_q[PIX_W-1]=0 AND in-range (see Configuration).
- DRAIN: when the last tag is output, pulse done and go to IDLE.
- start while busy: ignored; no queueing.
- abort (any state except IDLE): flush all tags, no further wren, no done pulse, go to IDLE next cycle. abort in IDLE: no effect.
- start and abort in the same IDLE cycle: start wins.
- Reset values: rom_addr=0, pixel_col=0, pixel_data=0, wren=0, busy=0, done=0, state IDLE, delay line cleared.
- Reset mid-row: immediate return to IDLE; no partial writes after deassertion.

## Timing
- T0 = cycle start is sampled high in IDLE.
- busy rises in T1.
- rom_addr for pixel i is valid in T1+i.
- Pixel i's pixel_col/pixel_data/wren are valid in T(2+i+ROM_LAT). All outputs are registered.
- done is high in T(1+SPR_W+ROM_LAT), coincident with the last pixel.
- busy falls in the following cycle.
- Throughput: one pixel per cycle. A new start is accepted at T(2+SPR_W+ROM_LAT), giving a row period of SPR_W+ROM_LAT+2 cycles.
- abort sampled in cycle Ta: wren=0 from Ta+1; busy=0 in Ta+1.

## Configuration
- SPRITE_CLIP_EN defined: in-range means the (COL_W+1)-bit column is < LINE_W; off-screen pixels get wren=0 but still consume their cycle.
- SPRITE_CLIP_EN undefined: in-range is always true; pixel_col wraps modulo 2^COL_W.

## Structure
- Package sprite_pkg: state enum (IDLE/FETCH/DRAIN), TRANSP_BIT constant, pixel typedef, AW helper function.
- Sub-module sprite_tag_pipe: parametrised ROM_LAT-deep shift register of {valid, index} with synchronous flush.
- Everything else stays in sprite_line_renderer.

## Test plan
- Defaults, col_base=100, frame 3, row 5, no flip, all pixels opaque:
  - rom_addr 0x0350..0x035F in T1..T16.
  - wren cols 100..115 in T3..T18.
  - done in T18.
- Horizontal and vertical flip:
  - hflip=1, vflip=1, row_off=5: addresses use row 10.
  - Pixel i is written to col_base+15-i.
- Transparency: rom_q[15]=1 on odd pixels.
  - Only even-indexed pixels are written.
  - done timing is unchanged.
- Clipping: col_base=630 with SPRITE_CLIP_EN.
  - Cols 630..639 are written, 640..645 are suppressed.
  - Without the macro, 640..645 wrap to 640..645 mod 1024 and are written.
- Abort: abort at T6.
  - No wren from T7; busy=0 in T7.
  - No done pulse.
  - A start in T7 runs normally.
- Reset and ROM latency:
  - reset_n pulsed low at T8: all outputs 0 immediately.
  - ROM_LAT=3 build: first pixel in T5, done in T20.

Source files
------------

// File: rtl/sprite_line_renderer_pkg.sv
// Shared types and helpers for the sprite row renderer (state encoding, pixel format,
// ROM address width).
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Transparency flag position for the default 16-bit pixel format.
  localparam int TRANSP_BIT = 15;

  typedef logic [TRANSP_BIT:0] pixel_t;

  function automatic int addr_width(input int frame_w, input int spr_h, input int spr_w);
    return frame_w + $clog2(spr_h) + $clog2(spr_w);
  endfunction

endpackage

// File: rtl/sprite_line_renderer_tag_pipe.sv
// Delay line carrying {valid, pixel index} alongside the ROM read latency, so each
// returning ROM word arrives with its pixel index. A flush kills every in-flight tag.
module sprite_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [DEPTH-1:0] valid_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int k = 1; k < DEPTH; k++) valid_q[k] <= valid_q[k-1];
    end
  end

  // NOTE: only the valid bits are reset; the index payload is meaningless while its
  // valid bit is low, so it is left as plain unreset flops.
  always_ff @(posedge clk) begin
    idx_q[0] <= in_idx;
    for (int k = 1; k < DEPTH; k++) idx_q[k] <= idx_q[k-1];
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/sprite_line_renderer.sv
// Fetches one row of one sprite frame from the sprite ROM and writes its opaque pixels
// to the line buffer. Define SPRITE_CLIP_EN to suppress writes at or beyond LINE_W.
module sprite_line_renderer
  import sprite_pkg::*;
#(
  parameter int SPR_W   = 16,
  parameter int SPR_H   = 16,
  parameter int FRAME_W = 8,
  parameter int PIX_W   = 16,
  parameter int COL_W   = 10,
  parameter int LINE_W  = 640,
  parameter int ROM_LAT = 1,
  localparam int AW     = addr_width(FRAME_W, SPR_H, SPR_W)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [COL_W-1:0]         col_base,
  input  logic [FRAME_W-1:0]       frame_id,
  input  logic [$clog2(SPR_H)-1:0] row_off,
  input  logic                     hflip,
  input  logic                     vflip,
  input  logic                     abort,
  output logic [AW-1:0]            rom_addr,
  input  logic [PIX_W-1:0]         rom_q,
  output logic [COL_W-1:0]         pixel_col,
  output logic [PIX_W-1:0]         pixel_data,
  output logic                     wren,
  output logic                     busy,
  output logic                     done
);

  localparam int ROW_W = $clog2(SPR_H);
  localparam int IDX_W = $clog2(SPR_W);
  localparam int TBIT  = (PIX_W == $bits(pixel_t)) ? TRANSP_BIT : PIX_W - 1;

  state_t           state;
  logic [COL_W-1:0] col_base_r;
  logic [FRAME_W-1:0] frame_r;
  logic [ROW_W-1:0] row_r;
  logic             hflip_r;
  logic [IDX_W-1:0] idx;

  logic             tag_valid;
  logic [IDX_W-1:0] tag_idx;
  logic             abort_hit;
  logic [IDX_W-1:0] col_off;
  logic [COL_W:0]   col_sum;
  logic             in_range;

  assign abort_hit = abort && (state != IDLE);

  sprite_tag_pipe #(
    .DEPTH (ROM_LAT),
    .IDX_W (IDX_W)
  ) u_tag_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (abort_hit),
    .in_valid  (state == FETCH),
    .in_idx    (idx),
    .out_valid (tag_valid),
    .out_idx   (tag_idx)
  );

  // NOTE: every state register is assigned with <= so all flops sample the same
  // pre-edge values; blocking assignments here would create ordering-dependent logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      idx        <= '0;
      rom_addr   <= '0;
      col_base_r <= '0;
      frame_r    <= '0;
      row_r      <= '0;
      hflip_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Heights are powers of two, so SPR_H-1-row_off is just the bitwise inverse.
            col_base_r <= col_base;
            frame_r    <= frame_id;
            row_r      <= vflip ? ~row_off : row_off;
            hflip_r    <= hflip;
            idx        <= '0;
            rom_addr   <= {frame_id, (vflip ? ~row_off : row_off), {IDX_W{1'b0}}};
            busy       <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (idx == IDX_W'(SPR_W - 1)) begin
            state <= DRAIN;
          end else begin
            idx      <= idx + 1'b1;
            rom_addr <= {frame_r, row_r, idx + 1'b1};
          end
        end
        DRAIN: begin
          // done is registered alongside the last pixel, so busy drops one cycle later.
          if (abort || done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign col_off = hflip_r ? ~tag_idx : tag_idx;
  assign col_sum = {1'b0, col_base_r} + (COL_W + 1)'(col_off);

`ifdef SPRITE_CLIP_EN
  assign in_range = (col_sum < (COL_W + 1)'(LINE_W));
`else
  logic unused_carry;
  assign in_range     = 1'b1;
  assign unused_carry = col_sum[COL_W] & (LINE_W != 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_col  <= '0;
      pixel_data <= '0;
      wren       <= 1'b0;
      done       <= 1'b0;
    end else if (abort_hit) begin
      wren <= 1'b0;
      done <= 1'b0;
    end else begin
      wren <= tag_valid && !rom_q[TBIT] && in_range;
      done <= tag_valid && (tag_idx == IDX_W'(SPR_W - 1));
      if (tag_valid) begin
        pixel_col  <= col_sum[COL_W-1:0];
        pixel_data <= rom_q;
      end
    end
  end

endmodule
